// File: rtl/branch_ctl_pkg.sv
// ----------------------------------------------------------------------------
// branch_ctl_pkg
//   Shared definitions for the EX-stage branch controller: controller state
//   encoding and the quick-compare select codes understood by the external
//   compare unit at cpu top.
//
//   Contents:
//     state_t       - branch controller states (IDLE, WAIT, CMP, RESOLVE)
//     QC_*          - six quick-compare select codes
//     qc_op_valid() - 1 when a select code is one of the six defined codes
// ----------------------------------------------------------------------------
package branch_ctl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_CMP     = 2'd2,
        ST_RESOLVE = 2'd3
    } state_t;

    localparam int QC_W = 6;

    // Quick-compare select codes. RS/RT are the bypassed operands; the
    // zero-compares look at RS only, as a signed 32-bit value.
    localparam logic [QC_W-1:0] QC_EQ  = 6'h01;  // RS == RT
    localparam logic [QC_W-1:0] QC_NE  = 6'h02;  // RS != RT
    localparam logic [QC_W-1:0] QC_LEZ = 6'h03;  // RS <= 0
    localparam logic [QC_W-1:0] QC_GTZ = 6'h04;  // RS >  0
    localparam logic [QC_W-1:0] QC_LTZ = 6'h05;  // RS <  0
    localparam logic [QC_W-1:0] QC_GEZ = 6'h06;  // RS >= 0

    function automatic logic qc_op_valid(input logic [QC_W-1:0] op);
        case (op)
            QC_EQ, QC_NE, QC_LEZ, QC_GTZ, QC_LTZ, QC_GEZ: return 1'b1;
            default:                                      return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/branch_ctl.sv
// ----------------------------------------------------------------------------
// branch_ctl
//   EX-stage branch controller. Accepts a branch, waits for both bypassed
//   operands, drives the external quick-compare unit for one cycle, then
//   resolves with a one-cycle Redirect pulse when taken.
//
//   Ports:
//     clk          in   clock, all state updates on rising edge
//     reset_n      in   asynchronous active-low reset
//     BrValid      in   EX-stage branch present
//     BrOp[5:0]    in   quick-compare select code of the branch
//     BrTarget[31:0] in branch target address
//     RSready      in   RS operand valid
//     RTready      in   RT operand valid
//     Flush        in   synchronous abort of the in-flight branch
//     QCresult     in   result from the external compare unit
//     BrLikely     in   branch-likely flag (BRANCH_LIKELY_EN only)
//     QCsel[5:0]   out  select to the compare unit (last latched op)
//     Stall        out  freeze fetch/decode (combinational)
//     Redirect     out  one-cycle taken pulse
//     RedirectPC[31:0] out target while Redirect=1, else 0
//     SquashDS     out  squash delay slot of a not-taken likely branch
//                       (BRANCH_LIKELY_EN only)
//     BadOp        out  one-cycle pulse for an unsupported BrOp
//
//   Configuration macro: BRANCH_LIKELY_EN adds BrLikely / SquashDS. Without
//   it the delay slot always executes.
// ----------------------------------------------------------------------------
module branch_ctl
    import branch_ctl_pkg::*;
(
    input  logic            clk,
    input  logic            reset_n,
    input  logic            BrValid,
    input  logic [QC_W-1:0] BrOp,
    input  logic [31:0]     BrTarget,
    input  logic            RSready,
    input  logic            RTready,
    input  logic            Flush,
    input  logic            QCresult,
`ifdef BRANCH_LIKELY_EN
    input  logic            BrLikely,
    output logic            SquashDS,
`endif
    output logic [QC_W-1:0] QCsel,
    output logic            Stall,
    output logic            Redirect,
    output logic [31:0]     RedirectPC,
    output logic            BadOp
);

    state_t          state_q, state_d;
    logic [QC_W-1:0] op_q;
    logic [31:0]     target_q;
    logic            taken_q;
    logic            likely_q;
    logic            accept;
    logic            ops_ready;
    logic            resolving;
    logic            likely_in;

`ifdef BRANCH_LIKELY_EN
    assign likely_in = BrLikely;
`else
    assign likely_in = 1'b0;
`endif

    assign ops_ready = RSready & RTready;

    // NOTE: every signal written here gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_RESOLVE: begin
                if (BrValid) begin
                    accept  = 1'b1;
                    state_d = ops_ready ? ST_CMP : ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: if (ops_ready) state_d = ST_CMP;
            ST_CMP:  state_d = ST_RESOLVE;
            default: state_d = ST_IDLE;
        endcase
        // Flush wins over everything, including a branch offered this cycle.
        if (Flush) begin
            accept  = 1'b0;
            state_d = ST_IDLE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            target_q <= '0;
            taken_q  <= 1'b0;
            likely_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q     <= BrOp;
                target_q <= BrTarget;
                likely_q <= likely_in;
            end
            // An undefined select code can never be taken, whatever the
            // compare unit answers for it.
            if (state_q == ST_CMP) begin
                taken_q <= QCresult & qc_op_valid(op_q);
            end
        end
    end

    // QCsel simply follows the latched op so the compare unit only toggles
    // when a new branch is accepted.
    assign QCsel = op_q;

    assign Stall = accept | (state_q == ST_WAIT) | (state_q == ST_CMP);

    // A Flush during RESOLVE aborts the branch being resolved as well.
    assign resolving  = (state_q == ST_RESOLVE) & ~Flush;
    assign Redirect   = resolving & taken_q;
    assign RedirectPC = Redirect ? target_q : 32'h0;
    assign BadOp      = resolving & ~qc_op_valid(op_q);

`ifdef BRANCH_LIKELY_EN
    assign SquashDS = resolving & likely_q & ~taken_q;
`else
    // Likely flag has no consumer without the squash output.
    logic unused_likely;
    assign unused_likely = likely_q;
`endif

endmodule

// File: tb/tb_branch_ctl.sv
// ----------------------------------------------------------------------------
// tb_branch_ctl
//   Self-checking bench for branch_ctl. A behavioural model of the in-flight
//   branch runs alongside the DUT and every output is compared on each
//   falling edge; directed scenarios add literal expectations on top.
//   The external compare unit is modelled here and fed from QCsel.
// ----------------------------------------------------------------------------
module tb_branch_ctl;
    import branch_ctl_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        br_valid, rs_ready, rt_ready, flush, qc_result, br_likely;
    logic [5:0]  br_op;
    logic [31:0] br_target;
    logic [31:0] rs_val, rt_val;
    logic [5:0]  qc_sel;
    logic        stall, redirect, bad_op, squash_ds;
    logic [31:0] redirect_pc;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    branch_ctl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .BrValid    (br_valid),
        .BrOp       (br_op),
        .BrTarget   (br_target),
        .RSready    (rs_ready),
        .RTready    (rt_ready),
        .Flush      (flush),
        .QCresult   (qc_result),
`ifdef BRANCH_LIKELY_EN
        .BrLikely   (br_likely),
        .SquashDS   (squash_ds),
`endif
        .QCsel      (qc_sel),
        .Stall      (stall),
        .Redirect   (redirect),
        .RedirectPC (redirect_pc),
        .BadOp      (bad_op)
    );

`ifndef BRANCH_LIKELY_EN
    assign squash_ds = 1'b0;
`endif

    // External compare unit. Undefined selects answer 1 so the bench can see
    // whether the controller forces such branches not-taken.
    function automatic logic ref_cmp(input logic [5:0] sel, input logic [31:0] rs,
                                     input logic [31:0] rt);
        case (sel)
            QC_EQ:   return rs == rt;
            QC_NE:   return rs != rt;
            QC_LEZ:  return $signed(rs) <= 0;
            QC_GTZ:  return $signed(rs) > 0;
            QC_LTZ:  return $signed(rs) < 0;
            QC_GEZ:  return $signed(rs) >= 0;
            default: return 1'b1;
        endcase
    endfunction

    function automatic bit op_defined(input logic [5:0] op);
        return op >= 6'h01 && op <= 6'h06;
    endfunction

    always_comb qc_result = ref_cmp(qc_sel, rs_val, rt_val);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // One in-flight branch: busy until its compare is done; operands_in says
    // the compare happens in the current cycle; result_due says its outcome
    // is reported in the current cycle.
    bit          m_busy, m_operands_in, m_result_due, m_taken, m_likely;
    logic [5:0]  m_op;
    logic [31:0] m_tgt;

    task automatic model_reset();
        m_busy = 0; m_operands_in = 0; m_result_due = 0; m_taken = 0; m_likely = 0;
        m_op = '0; m_tgt = '0;
    endtask

    initial begin : model_compare
        bit          acc, fire, e_redir, n_busy, n_in, n_due, n_taken, n_likely;
        logic [5:0]  n_op;
        logic [31:0] n_tgt;
        model_reset();
        forever begin
            @(negedge clk);
            if (!reset_n) model_reset();
            acc     = br_valid && !flush && !m_busy;
            fire    = m_result_due && !flush;
            e_redir = fire && m_taken;
            check("m_qcsel",    qc_sel,      m_op);
            check("m_stall",    stall,       m_busy || acc);
            check("m_redirect", redirect,    e_redir);
            check("m_redir_pc", redirect_pc, e_redir ? m_tgt : 32'h0);
            check("m_badop",    bad_op,      fire && !op_defined(m_op));
`ifdef BRANCH_LIKELY_EN
            check("m_squash",   squash_ds,   fire && m_likely && !m_taken);
`endif
            n_busy = m_busy; n_in = m_operands_in; n_due = m_result_due; n_taken = m_taken;
            n_likely = m_likely; n_op = m_op; n_tgt = m_tgt;
            if (flush) begin
                n_busy = 0; n_due = 0;
            end else if (m_busy && m_operands_in) begin
                n_busy  = 0; n_due = 1;
                n_taken = op_defined(m_op) && ref_cmp(m_op, rs_val, rt_val);
            end else if (m_busy) begin
                n_in = rs_ready && rt_ready;
            end else begin
                n_due = 0;
                if (acc) begin
                    n_busy = 1; n_in = rs_ready && rt_ready;
                    n_op = br_op; n_tgt = br_target;
`ifdef BRANCH_LIKELY_EN
                    n_likely = br_likely;
`else
                    n_likely = 0;
`endif
                end
            end
            @(posedge clk);
            if (reset_n) begin
                m_busy = n_busy; m_operands_in = n_in; m_result_due = n_due;
                m_taken = n_taken; m_likely = n_likely; m_op = n_op; m_tgt = n_tgt;
            end else begin
                model_reset();
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic quiet();
        br_valid = 0; flush = 0; rs_ready = 1; rt_ready = 1; br_likely = 0;
    endtask

    task automatic offer(input logic [5:0] op, input logic [31:0] tgt);
        br_valid = 1; br_op = op; br_target = tgt;
    endtask

    initial begin : main
        logic [31:0] pool [5];
        pool[0] = 32'h0; pool[1] = 32'h5; pool[2] = 32'hFFFF_FFFF;
        pool[3] = 32'h8000_0000; pool[4] = 32'h1;

        reset_n = 0; quiet(); br_op = '0; br_target = '0; rs_val = 0; rt_val = 0;
        #2;
        check("rst_stall", stall, 0);
        check("rst_redir", redirect, 0);
        check("rst_pc", redirect_pc, 0);
        check("rst_qcsel", qc_sel, 0);
        check("rst_badop", bad_op, 0);
        check("rst_squash", squash_ds, 0);
        cyc(); reset_n = 1;

        // Ready-operand taken branch
        cyc(); offer(QC_EQ, 32'h0040_0040); rs_val = 5; rt_val = 5;
        mid(); check("t1_stall_n", stall, 1);
        cyc(); br_valid = 0;
        mid(); check("t1_stall_n1", stall, 1); check("t1_qcsel", qc_sel, QC_EQ);
        cyc();
        mid(); check("t1_redir", redirect, 1); check("t1_pc", redirect_pc, 32'h0040_0040);
               check("t1_stall_n2", stall, 0);
        cyc();
        mid(); check("t1_redir_end", redirect, 0); check("t1_pc_end", redirect_pc, 0);

        // Not-taken branch
        cyc(); offer(QC_NE, 32'h0040_0080); rs_val = 9; rt_val = 9;
        cyc(); br_valid = 0;
        cyc();
        mid(); check("t2_redir", redirect, 0); check("t2_stall", stall, 0);
               check("t2_pc", redirect_pc, 0);

        // Operand wait: RTready low for 3 cycles starting with the accept
        cyc(); offer(QC_EQ, 32'h0000_1000); rs_val = 3; rt_val = 3; rt_ready = 0;
        mid(); check("t3_stall0", stall, 1);
        for (int i = 1; i <= 4; i++) begin
            cyc(); br_valid = 0; rt_ready = (i >= 3);
            mid(); check($sformatf("t3_stall%0d", i), stall, 1);
                   check($sformatf("t3_noredir%0d", i), redirect, 0);
        end
        cyc();
        mid(); check("t3_redir", redirect, 1); check("t3_pc", redirect_pc, 32'h0000_1000);

        // Flush in CMP
        cyc(); offer(QC_EQ, 32'h0000_2000); rs_val = 1; rt_val = 1;
        cyc(); br_valid = 0; flush = 1;
        cyc(); flush = 0;
        mid(); check("t4_redir", redirect, 0); check("t4_stall", stall, 0);
        cyc();
        mid(); check("t4_redir2", redirect, 0);

        // Back-to-back: second branch offered while the first resolves
        cyc(); offer(QC_EQ, 32'h0000_3000); rs_val = 7; rt_val = 7;
        cyc(); br_valid = 0;
        cyc(); offer(QC_NE, 32'h0000_4000); rt_val = 8;
        mid(); check("t5_redir_a", redirect, 1); check("t5_pc_a", redirect_pc, 32'h0000_3000);
               check("t5_stall", stall, 1);
        cyc(); br_valid = 0;
        mid(); check("t5_cmp_qcsel", qc_sel, QC_NE);
        cyc();
        mid(); check("t5_redir_b", redirect, 1); check("t5_pc_b", redirect_pc, 32'h0000_4000);

        // Undefined op
        cyc(); offer(6'h3F, 32'h0000_5000);
        cyc(); br_valid = 0;
        cyc();
        mid(); check("t6_badop", bad_op, 1); check("t6_redir", redirect, 0);
        cyc();
        mid(); check("t6_badop_end", bad_op, 0);

`ifdef BRANCH_LIKELY_EN
        // Likely gez with a negative RS: not taken, delay slot squashed
        cyc(); offer(QC_GEZ, 32'h0000_6000); br_likely = 1; rs_val = 32'h8000_0000;
        cyc(); br_valid = 0; br_likely = 0;
        cyc();
        mid(); check("t7_squash", squash_ds, 1); check("t7_redir", redirect, 0);
        cyc();
        mid(); check("t7_squash_end", squash_ds, 0);
`endif

        // Reset mid-branch discards it
        cyc(); offer(QC_EQ, 32'h0000_7000); rs_val = 2; rt_val = 2;
        cyc(); br_valid = 0; reset_n = 0;
        #1; check("t8_stall_rst", stall, 0); check("t8_qcsel_rst", qc_sel, 0);
        cyc(); reset_n = 1;
        for (int i = 0; i < 3; i++) begin
            mid(); check($sformatf("t8_noredir%0d", i), redirect, 0);
            cyc();
        end

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cyc();
            if ($urandom_range(0, 299) == 0) begin
                quiet(); reset_n = 0;
                cyc(); reset_n = 1;
            end
            br_valid  = $urandom_range(0, 1);
            br_op     = ($urandom_range(0, 9) == 0) ? 6'($urandom) : 6'($urandom_range(1, 6));
            br_target = $urandom;
            rs_ready  = $urandom_range(0, 9) < 7;
            rt_ready  = $urandom_range(0, 9) < 7;
            flush     = $urandom_range(0, 19) == 0;
            br_likely = $urandom_range(0, 1);
            rs_val    = pool[$urandom_range(0, 4)];
            rt_val    = pool[$urandom_range(0, 4)];
        end
        cyc(); quiet();
        mid();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
